matmul_result_tx: RTL and testbench

Result-side transmitter for the matrix-multiply datapath. On a start pulse it snapshots the N×M result matrix C and its per-element overflow flags, then streams the elements one per handshake over a valid/ready bus carrying row/column indices and a last flag. It sits between the C accumulator array and the output bus that the golden checker and coverage monitors sample. It is the producer end of that bus.

---
 rtl/matmul_result_tx.sv | 156 +++++++++++++++
 tb/tb_matmul_result_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_tx.sv
// matmul_result_tx: snapshots the N x M result matrix C and its overflow
// flags on a start pulse. It then streams one element per valid/ready
// handshake, in row-major or column-major order, with row/col indices and a
// last flag. Every output comes straight from a flop.
module matmul_result_tx #(
  parameter int N          = 4,
  parameter int M          = 4,
  parameter int DATA_WIDTH = 16,
  localparam int RW        = (N > 1) ? $clog2(N) : 1,
  localparam int CW        = (M > 1) ? $clog2(M) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         order_i,
  input  logic [N*M*DATA_WIDTH-1:0]    mat_c_i,
  input  logic [N*M-1:0]               ovf_i,
  input  logic                         tx_ready_i,
  output logic                         tx_valid_o,
  output logic [DATA_WIDTH-1:0]        tx_data_o,
  output logic [RW-1:0]                tx_row_o,
  output logic [CW-1:0]                tx_col_o,
  output logic                         tx_ovf_o,
  output logic                         tx_last_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(M - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                      state, state_next;
  logic [N*M*DATA_WIDTH-1:0]   snap_c;
  logic [N*M-1:0]              snap_ovf;
  logic                        order;
  logic [RW-1:0]               row, row_next;
  logic [CW-1:0]               col, col_next;
  logic                        load;
  logic                        handshake;

  logic [N*M*DATA_WIDTH-1:0]   src_c;
  logic [N*M-1:0]              src_ovf;
  int                          idx;
  logic                        valid_next;
  logic [DATA_WIDTH-1:0]       data_next;
  logic                        ovf_next;
  logic                        last_next;

  // The ready input only steers next-state logic. It never reaches an output
  // without passing through a flop.
  assign handshake = tx_valid_o & tx_ready_i;

  // Next-state and index advance: start, walk the matrix in the selected order, finish
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    state_next = state;
    row_next   = row;
    col_next   = col;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          load       = 1'b1;
          row_next   = '0;
          col_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (tx_last_o) begin
            state_next = DONE;
          end else if (!order) begin
            if (col == COL_LAST) begin
              col_next = '0;
              row_next = row + RW'(1);
            end else begin
              col_next = col + CW'(1);
            end
          end else begin
            if (row == ROW_LAST) begin
              row_next = '0;
              col_next = col + CW'(1);
            end else begin
              row_next = row + RW'(1);
            end
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat decode for the next cycle. On the start cycle it reads the live
  // inputs, because the snapshot is being written on that same edge.
  always_comb begin
    src_c      = load ? mat_c_i : snap_c;
    src_ovf    = load ? ovf_i   : snap_ovf;
    idx        = int'(row_next) * M + int'(col_next);
    valid_next = (state_next == SEND);
    data_next  = '0;
    ovf_next   = 1'b0;
    last_next  = 1'b0;
    if (valid_next) begin
      data_next = src_c[idx*DATA_WIDTH +: DATA_WIDTH];
      ovf_next  = src_ovf[idx];
      last_next = (row_next == ROW_LAST) && (col_next == COL_LAST);
    end
  end

  // State, counters, snapshot and registered outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the statements are in.
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      // NOTE: the snapshot is reset as well. It is one wide register, not a
      // RAM, so clearing it is cheap and keeps reset state fully defined.
      snap_c     <= '0;
      snap_ovf   <= '0;
      order      <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      tx_row_o   <= '0;
      tx_col_o   <= '0;
      tx_ovf_o   <= 1'b0;
      tx_last_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state <= state_next;
      row   <= row_next;
      col   <= col_next;
      if (load) begin
        snap_c   <= mat_c_i;
        snap_ovf <= ovf_i;
        order    <= order_i;
      end
      tx_valid_o <= valid_next;
      tx_data_o  <= data_next;
      tx_row_o   <= valid_next ? row_next : '0;
      tx_col_o   <= valid_next ? col_next : '0;
      tx_ovf_o   <= ovf_next;
      tx_last_o  <= last_next;
      busy_o     <= (state_next != IDLE);
      done_o     <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_matmul_result_tx.sv
// Directed bench for matmul_result_tx at the default 4x4 size. Expected beats
// are rebuilt from C(r,c) = 16r + c with only element (1,1) flagged.
module tb_matmul_result_tx;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int DW = 16;
  localparam int NM = N * M;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              order_i = 1'b0;
  logic [NM*DW-1:0]  mat_c_i = '0;
  logic [NM-1:0]     ovf_i = '0;
  logic              tx_ready_i = 1'b0;
  logic              tx_valid_o;
  logic [DW-1:0]     tx_data_o;
  logic [1:0]        tx_row_o;
  logic [1:0]        tx_col_o;
  logic              tx_ovf_o;
  logic              tx_last_o;
  logic              busy_o;
  logic              done_o;

  int n_cmp = 0;
  int n_err = 0;

  matmul_result_tx #(.N(N), .M(M), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .order_i    (order_i),
    .mat_c_i    (mat_c_i),
    .ovf_i      (ovf_i),
    .tx_ready_i (tx_ready_i),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_row_o   (tx_row_o),
    .tx_col_o   (tx_col_o),
    .tx_ovf_o   (tx_ovf_o),
    .tx_last_o  (tx_last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_out();
    return 64'({tx_valid_o, tx_data_o, tx_row_o, tx_col_o, tx_ovf_o, tx_last_o, busy_o, done_o});
  endfunction

  task automatic load_matrix();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++)
        mat_c_i[(r*M+c)*DW +: DW] = DW'(16 * r + c);
    ovf_i = 16'h0020;
  endtask

  // Compare the visible beat against the expected beat number b
  task automatic check_beat(input bit ord, input int b);
    int r;
    int c;
    r = ord ? (b % N) : (b / M);
    c = ord ? (b / N) : (b % M);
    check($sformatf("valid[%0d]", b), 64'(tx_valid_o), 64'd1);
    check($sformatf("data[%0d]", b), 64'(tx_data_o), 64'(16 * r + c));
    check($sformatf("row[%0d]", b), 64'(tx_row_o), 64'(r));
    check($sformatf("col[%0d]", b), 64'(tx_col_o), 64'(c));
    check($sformatf("ovf[%0d]", b), 64'(tx_ovf_o), 64'(r == 1 && c == 1));
    check($sformatf("last[%0d]", b), 64'(tx_last_o), 64'(b == NM - 1));
    check($sformatf("busy[%0d]", b), 64'(busy_o), 64'd1);
    check($sformatf("done[%0d]", b), 64'(done_o), 64'd0);
  endtask

  // One full transfer. ready_pct sets the ready duty cycle. poke corrupts
  // the inputs and pulses start mid-transfer and again during DONE.
  task automatic run_stream(input bit ord, input int ready_pct, input bit poke);
    int  beat;
    int  cyc;
    bit  poked;
    beat  = 0;
    cyc   = 0;
    poked = 1'b0;
    load_matrix();
    order_i = ord;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    order_i = ~ord;
    while (beat < NM && cyc < 200) begin
      tx_ready_i = ($urandom_range(99) < ready_pct);
      check_beat(ord, beat);
      if (poke && beat == 5 && !poked) begin
        mat_c_i = ~mat_c_i;
        ovf_i   = ~ovf_i;
        start_i = 1'b1;
        poked   = 1'b1;
      end
      step();
      start_i = 1'b0;
      if (tx_ready_i) beat++;
      cyc++;
    end
    check("handshakes", 64'(beat), 64'(NM));
    if (ready_pct == 100) check("beat_cycles", 64'(cyc), 64'(NM));
    check("done_pulse", 64'(done_o), 64'd1);
    check("done_busy", 64'(busy_o), 64'd1);
    check("done_valid", 64'(tx_valid_o), 64'd0);
    if (poke) start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("post_done", 64'(done_o), 64'd0);
    check("post_busy", 64'(busy_o), 64'd0);
    check("post_valid", 64'(tx_valid_o), 64'd0);
    step();
    check("no_restart", all_out(), 64'd0);
    tx_ready_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three edges, then ten idle cycles
    rst_n = 1'b0;
    repeat (3) begin
      step();
      check("reset_out", all_out(), 64'd0);
    end
    rst_n = 1'b1;
    repeat (10) begin
      step();
      check("idle_out", all_out(), 64'd0);
    end

    run_stream(1'b0, 100, 1'b0);   // row-major, ready tied high
    run_stream(1'b1, 100, 1'b0);   // column-major, ready tied high
    run_stream(1'b0, 30, 1'b0);    // row-major under backpressure
    run_stream(1'b1, 30, 1'b0);    // column-major under backpressure
    run_stream(1'b0, 30, 1'b1);    // snapshot held, late starts ignored

    // Abort at beat 7, then a clean restart
    load_matrix();
    order_i    = 1'b0;
    tx_ready_i = 1'b1;
    start_i    = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_beat(1'b0, i);
      step();
    end
    rst_n = 1'b0;
    step();
    check("abort_out", all_out(), 64'd0);
    rst_n = 1'b1;
    repeat (5) begin
      step();
      check("abort_quiet", all_out(), 64'd0);
    end
    run_stream(1'b0, 100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
